// File: rtl/multdiv_iter_if.sv
// ============================================================================
// Module      : multdiv_iter_if
// Description : Operation/result bundle between the pipeline X stage and the
//               iterative multiply/divide unit.
//               master : pipeline side (drives start strobes and operands)
//               slave  : multdiv_iter side (drives result, flags and busy)
//   ctrl_MULT / ctrl_DIV          start strobes
//   data_operandA / data_operandB operands
//   data_result / data_exception  result and overflow/div-by-zero flag
//   data_resultRDY                one-cycle result-valid pulse
//   busy                          stall request
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multdiv_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ============================================================================
// Module      : multdiv_iter
// Description : Iterative signed multiply (radix-2 Booth) / divide (restoring,
//               on magnitudes) unit. One op per start strobe; WIDTH iteration
//               cycles followed by one DONE cycle carrying data_resultRDY.
// Ports       : clock - rising-edge clock
//               reset - synchronous, active-high
//               bus   - multdiv_iter_if.slave (strobes, operands, results)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic     clock,
  input  wire logic     reset,
  multdiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] count;
  logic             op_mult;
  logic             sign_neg;   // quotient sign for divide
  logic             div_zero;
  // Shared iteration registers:
  //   multiply: acc = Booth accumulator (one guard bit), q = multiplier, qm1 = Booth bit
  //   divide  : acc = partial remainder, q = dividend magnitude -> quotient
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH-1:0] mcand;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] result;
  logic             exception;

  logic start, last;
  assign start = ((state == IDLE) || (state == DONE)) && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign last  = (count == CNT_W'(WIDTH - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- one iteration step ----------------
  logic [WIDTH:0]   mcand_ext, booth_sum, booth_acc, div_shift, div_acc, step_acc;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] booth_q, div_q, step_q, quot_signed;
  logic             step_qm1;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]   prod_high;
  logic             mult_exc, div_exc;

  always_comb begin
    mcand_ext = {mcand[WIDTH-1], mcand};
    booth_sum = acc;
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    // Arithmetic shift right of {acc, q, qm1}
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q[WIDTH-1:1]};

    // Restoring step: shift next dividend bit in, keep the difference if non-negative
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, mcand};
    if (!div_diff[WIDTH+1]) begin
      div_acc = div_diff[WIDTH:0];
      div_q   = {q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = div_shift;
      div_q   = {q[WIDTH-2:0], 1'b0};
    end

    step_acc = op_mult ? booth_acc : div_acc;
    step_q   = op_mult ? booth_q   : div_q;
    step_qm1 = op_mult ? q[0]      : 1'b0;

    // Product fits WIDTH signed bits only when bits [2W-1:W-1] all equal the sign
    product   = {step_acc[WIDTH-1:0], step_q};
    prod_high = product[2*WIDTH-1:WIDTH-1];
    mult_exc  = !((&prod_high) || (~|prod_high));

    quot_signed = sign_neg ? (~step_q + 1'b1) : step_q;
    // A positive quotient with the top bit set can only come from MIN / -1
    div_exc     = div_zero || (!sign_neg && step_q[WIDTH-1]);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      op_mult   <= 1'b0;
      sign_neg  <= 1'b0;
      div_zero  <= 1'b0;
      acc       <= '0;
      q         <= '0;
      qm1       <= 1'b0;
      mcand     <= '0;
      result    <= '0;
      exception <= 1'b0;
    end else if (start) begin
      count    <= '0;
      op_mult  <= bus.ctrl_MULT;
      acc      <= '0;
      qm1      <= 1'b0;
      sign_neg <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      div_zero <= (bus.data_operandB == '0);
      if (bus.ctrl_MULT) begin
        q     <= bus.data_operandA;
        mcand <= bus.data_operandB;
      end else begin
        // Two's-complement negate; MIN maps to 2**(W-1) read as unsigned
        q     <= bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
        mcand <= bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
      end
    end else if (state == RUN) begin
      acc   <= step_acc;
      q     <= step_q;
      qm1   <= step_qm1;
      count <= count + CNT_W'(1);
      if (last) begin
        if (op_mult) begin
          result    <= product[WIDTH-1:0];
          exception <= mult_exc;
        end else begin
          result    <= div_zero ? '0 : quot_signed;
          exception <= div_exc;
        end
      end
    end
  end

  assign bus.data_result    = result;
  assign bus.data_exception = exception;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_iter.sv
// ============================================================================
// Module      : tb_multdiv_iter
// Description : Directed self-checking bench for multdiv_iter (WIDTH=32),
//               plus a short run of random ops against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_iter;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_iter_if #(.WIDTH(W)) bus ();

  multdiv_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; the start edge is consumed here, returns at the next negedge.
  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  // Counts edges after the start edge until RDY is seen (bounded).
  task automatic wait_rdy(input int n0, output int n);
    n = n0;
    while (!bus.data_resultRDY && n < 200) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
  endtask

  task automatic run_check(input string tag, input bit m, input bit d,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_r, input logic exp_e);
    int n;
    @(negedge clock);
    issue(m, d, a, b);
    wait_rdy(0, n);
    check({tag, ".lat"}, 64'(n), 64'd32);
    check({tag, ".res"}, 64'(bus.data_result), 64'(exp_r));
    check({tag, ".exc"}, 64'(bus.data_exception), 64'(exp_e));
  endtask

  function automatic void model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint p;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      e = (p != longint'($signed(r)));
    end else if (b == '0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  initial begin
    int n, extra;
    logic [W-1:0] ra, rb, er;
    logic ee;
    bit rm;

    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.rdy",  64'(bus.data_resultRDY), 64'd0);
    check("rst.res",  64'(bus.data_result), 64'd0);
    check("rst.exc",  64'(bus.data_exception), 64'd0);
    reset = 1'b0;

    // Directed multiplies
    run_check("mul_3x-7",     1, 0, 32'd3,          32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0);
    run_check("mul_max_x2",   1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1);
    run_check("mul_min_x-1",  1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_check("mul_-6x-7",    1, 0, 32'hFFFF_FFFA,  32'hFFFF_FFF9, 32'd42,        1'b0);
    run_check("mul_pos2^31",  1, 0, 32'h0001_0000,  32'h0000_8000, 32'h8000_0000, 1'b1);
    run_check("mul_neg2^31",  1, 0, 32'h0001_0000,  32'hFFFF_8000, 32'h8000_0000, 1'b0);
    run_check("both_hi",      1, 1, 32'd6,          32'd7,         32'd42,        1'b0);
    // Directed divides
    run_check("div_-20/3",    0, 1, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0);
    run_check("div_5/0",      0, 1, 32'd5,          32'd0,         32'd0,         1'b1);
    run_check("div_min/-1",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_check("div_100/-7",   0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    run_check("div_-7/2",     0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_check("div_min/1",    0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
    run_check("div_3/7",      0, 1, 32'd3,          32'd7,         32'd0,         1'b0);

    // Start strobe and operand change during RUN are ignored
    @(negedge clock);
    issue(1, 0, 32'd3, 32'hFFFF_FFF9);
    n = 0;
    repeat (5) begin @(posedge clock); n++; @(negedge clock); end
    bus.ctrl_DIV = 1'b1;
    bus.data_operandA = 32'h1234_5678;
    bus.data_operandB = 32'h0000_0011;
    @(posedge clock); n++; @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    wait_rdy(n, n);
    check("run_ign.lat", 64'(n), 64'd32);
    check("run_ign.res", 64'(bus.data_result), 64'hFFFF_FFEB);
    extra = 0;
    repeat (40) begin
      @(posedge clock); @(negedge clock);
      if (bus.data_resultRDY) extra++;
    end
    check("run_ign.extra_rdy", 64'(extra), 64'd0);

    // Back-to-back: second start in the DONE cycle
    @(negedge clock);
    issue(1, 0, 32'd3, 32'hFFFF_FFF9);
    wait_rdy(0, n);
    check("b2b.res1", 64'(bus.data_result), 64'hFFFF_FFEB);
    issue(0, 1, 32'hFFFF_FFEC, 32'd3);
    wait_rdy(0, n);
    check("b2b.gap",  64'(n + 1), 64'd33);
    check("b2b.res2", 64'(bus.data_result), 64'hFFFF_FFFA);

    // Reset at iteration 10 aborts the op
    @(negedge clock);
    issue(1, 0, 32'h7FFF_FFFF, 32'd2);
    repeat (9) begin @(posedge clock); @(negedge clock); end
    reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    check("rst_mid.res",  64'(bus.data_result), 64'd0);
    check("rst_mid.exc",  64'(bus.data_exception), 64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clock); @(negedge clock);
      if (bus.data_resultRDY) extra++;
    end
    check("rst_mid.no_rdy", 64'(extra), 64'd0);
    run_check("post_rst", 1, 0, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0);

    // Random ops with gaps against the behavioural model
    for (int i = 0; i < 60; i++) begin
      rm = $urandom_range(0, 1) == 1;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(0, 15)) - 32'd8;
        2:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) ra = ra >>> $urandom_range(0, 31);
      model(rm, ra, rb, er, ee);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_check($sformatf("rnd%0d", i), rm, !rm, ra, rb, er, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
